mmio_bus: RTL and testbench



---
 rtl/mmio_bus_pkg.sv | 80 ++++++++
 rtl/mmio_bus_if.sv | 24 ++
 rtl/mmio_bus_kbd_fifo.sv | 83 ++++++++
 rtl/mmio_bus.sv | 135 +++++++++++++
 tb/tb_mmio_bus.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_bus_pkg.sv
// Shared constants and helpers for the memory-mapped I/O bus: region nibbles,
// device register addresses, keyboard status layout and the address decoder.
package mmio_pkg;

   localparam logic [3:0] REGION_RAM  = 4'h0;
   localparam logic [3:0] REGION_VRAM = 4'h1;
   localparam logic [3:0] REGION_ROM  = 4'h2;

   localparam logic [31:0] ADDR_SWITCH     = 32'hf000_0000;
   localparam logic [31:0] ADDR_SEG7       = 32'hf000_0004;
   localparam logic [31:0] ADDR_VGAMODE    = 32'hf000_0008;
   localparam logic [31:0] ADDR_FORECOLOR  = 32'hf000_000c;
   localparam logic [31:0] ADDR_BACKCOLOR  = 32'hf000_0010;
   localparam logic [31:0] ADDR_KBD_DATA   = 32'hf000_0014;
   localparam logic [31:0] ADDR_KBD_STATUS = 32'hf000_0018;
   localparam logic [31:0] ADDR_TIMER      = 32'hf000_001c;

   localparam int STAT_NEMPTY_BIT = 0;
   localparam int STAT_FULL_BIT   = 1;
   localparam int STAT_COUNT_LSB  = 8;

   localparam logic [11:0] BACKCOLOR_RST = 12'hfff;

   typedef enum logic {
      HS_IDLE,
      HS_ACK
   } hs_state_e;

   typedef enum logic [3:0] {
      SEL_NONE,
      SEL_RAM,
      SEL_VRAM,
      SEL_ROM,
      SEL_SWITCH,
      SEL_SEG7,
      SEL_VGAMODE,
      SEL_FORECOLOR,
      SEL_BACKCOLOR,
      SEL_KBD_DATA,
      SEL_KBD_STATUS,
      SEL_TIMER
   } sel_e;

   // Memory regions match on the top nibble; devices need an exact address.
   function automatic sel_e decode_addr(input logic [31:0] addr);
      sel_e sel;
      sel = SEL_NONE;
      case (addr[31:28])
         REGION_RAM:  sel = SEL_RAM;
         REGION_VRAM: sel = SEL_VRAM;
         REGION_ROM:  sel = SEL_ROM;
         default: begin
            case (addr)
               ADDR_SWITCH:     sel = SEL_SWITCH;
               ADDR_SEG7:       sel = SEL_SEG7;
               ADDR_VGAMODE:    sel = SEL_VGAMODE;
               ADDR_FORECOLOR:  sel = SEL_FORECOLOR;
               ADDR_BACKCOLOR:  sel = SEL_BACKCOLOR;
               ADDR_KBD_DATA:   sel = SEL_KBD_DATA;
               ADDR_KBD_STATUS: sel = SEL_KBD_STATUS;
               ADDR_TIMER:      sel = SEL_TIMER;
               default:         sel = SEL_NONE;
            endcase
         end
      endcase
      return sel;
   endfunction

   function automatic logic [31:0] kbd_status(input logic       not_empty,
                                              input logic       full,
                                              input logic [7:0] count);
      logic [31:0] s;
      s = '0;
      s[STAT_NEMPTY_BIT] = not_empty;
      s[STAT_FULL_BIT]   = full;
      s[STAT_COUNT_LSB +: 8] = count;
      return s;
   endfunction

endpackage

// File: rtl/mmio_bus_if.sv
// CPU data-port bus: byte address, write data, strobes and combinational read data.
interface mmio_bus_if;
   logic [31:0] addr4CPU;
   logic [31:0] data4CPU;
   logic        we4CPU;
   logic        re4CPU;
   logic [31:0] data2CPU;

   modport master (
      output addr4CPU,
      output data4CPU,
      output we4CPU,
      output re4CPU,
      input  data2CPU
   );

   modport slave (
      input  addr4CPU,
      input  data4CPU,
      input  we4CPU,
      input  re4CPU,
      output data2CPU
   );
endinterface

// File: rtl/mmio_bus_kbd_fifo.sv
// Scancode FIFO with a four-phase handshake toward the keyboard controller:
// one push per KBDready pulse, back-pressure by withholding the acknowledge.
module kbd_fifo
   import mmio_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     kbd_ready,
   input  logic [7:0]               scancode,
   output logic                     kbd_read,
   input  logic                     pop_req,
   output logic [7:0]               head,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   hs_state_e     state_q, state_d;
   logic          kbd_read_q, kbd_read_d;
   logic          push, pop;

   // Full/empty come from the registered count, so a pop at full cannot
   // enable a push in the same cycle.
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign push  = (state_q == HS_IDLE) && kbd_ready && !full;
   assign pop   = pop_req && !empty;

   assign kbd_read = kbd_read_q;
   assign count    = count_q;
   assign head     = empty ? 8'h00 : mem_q[rd_ptr_q];

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      case (state_q)
         HS_IDLE: if (push)       state_d = HS_ACK;
         HS_ACK:  if (!kbd_ready) state_d = HS_IDLE;
         default:                 state_d = HS_IDLE;
      endcase
      kbd_read_d = (state_d == HS_ACK);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= HS_IDLE;
         kbd_read_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         kbd_read_q <= kbd_read_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Storage needs no reset: reads are masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_q[wr_ptr_q] <= scancode;
      end
   end

endmodule

// File: rtl/mmio_bus.sv
// Memory-mapped I/O bus between the CPU data port and RAM, VRAM, ROM, device
// registers, the keyboard scancode FIFO and a loadable cycle timer.
module mmio_bus
   import mmio_pkg::*;
#(
   parameter int RAM_AW    = 12,
   parameter int VRAM_AW   = 19,
   parameter int VRAM_DW   = 12,
   parameter int KBD_DEPTH = 8,
   parameter int TIMER_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   mmio_bus_if.slave          cpu,
   output logic [RAM_AW-1:0]  addr2RAM,
   input  logic [31:0]        data4RAM,
   output logic               we2RAM,
   output logic [31:0]        data2RAM,
   output logic [VRAM_AW-1:0] addr2VRAM,
   input  logic [VRAM_DW-1:0] data4VRAM,
   output logic               we2VRAM,
   output logic [VRAM_DW-1:0] data2VRAM,
   output logic [31:0]        addr2ROM,
   input  logic [31:0]        data4ROM,
   input  logic [15:0]        switch,
   output logic [31:0]        seg7led,
   output logic               VGAmode,
   output logic [11:0]        forecolor,
   output logic [11:0]        backcolor,
   input  logic               KBDready,
   input  logic [7:0]         scancode,
   output logic               KBDread
);

   localparam int KCW = $clog2(KBD_DEPTH) + 1;

   sel_e               sel;
   logic               dev_we;
   logic [31:0]        seg7_q, seg7_d;
   logic               vga_mode_q, vga_mode_d;
   logic [11:0]        fore_q, fore_d;
   logic [11:0]        back_q, back_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [7:0]         kbd_head;
   logic               kbd_empty, kbd_full;
   logic [KCW-1:0]     kbd_count;
   logic               kbd_pop_req;

   assign sel    = decode_addr(cpu.addr4CPU);
   assign dev_we = cpu.we4CPU;

   assign addr2RAM  = cpu.addr4CPU[RAM_AW+1:2];
   assign data2RAM  = cpu.data4CPU;
   assign we2RAM    = dev_we && (sel == SEL_RAM);
   assign addr2VRAM = cpu.addr4CPU[VRAM_AW+1:2];
   assign data2VRAM = cpu.data4CPU[VRAM_DW-1:0];
   assign we2VRAM   = dev_we && (sel == SEL_VRAM);
   assign addr2ROM  = cpu.addr4CPU;

   assign seg7led   = seg7_q;
   assign VGAmode   = vga_mode_q;
   assign forecolor = fore_q;
   assign backcolor = back_q;

   assign kbd_pop_req = cpu.re4CPU && (sel == SEL_KBD_DATA);

   kbd_fifo #(
      .DEPTH (KBD_DEPTH)
   ) u_kbd_fifo (
      .clk       (clk),
      .rst       (rst),
      .kbd_ready (KBDready),
      .scancode  (scancode),
      .kbd_read  (KBDread),
      .pop_req   (kbd_pop_req),
      .head      (kbd_head),
      .empty     (kbd_empty),
      .full      (kbd_full),
      .count     (kbd_count)
   );

   // Register file and timer next-state; a timer load overrides the increment.
   always_comb begin
      seg7_d     = seg7_q;
      vga_mode_d = vga_mode_q;
      fore_d     = fore_q;
      back_d     = back_q;
      timer_d    = timer_q + TIMER_W'(1);
      if (dev_we) begin
         case (sel)
            SEL_SEG7:      seg7_d     = cpu.data4CPU;
            SEL_VGAMODE:   vga_mode_d = cpu.data4CPU[0];
            SEL_FORECOLOR: fore_d     = cpu.data4CPU[11:0];
            SEL_BACKCOLOR: back_d     = cpu.data4CPU[11:0];
            SEL_TIMER:     timer_d    = cpu.data4CPU[TIMER_W-1:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg7_q     <= '0;
         vga_mode_q <= 1'b0;
         fore_q     <= '0;
         back_q     <= BACKCOLOR_RST;
         timer_q    <= '0;
      end else begin
         seg7_q     <= seg7_d;
         vga_mode_q <= vga_mode_d;
         fore_q     <= fore_d;
         back_q     <= back_d;
         timer_q    <= timer_d;
      end
   end

   always_comb begin
      cpu.data2CPU = '0;
      case (sel)
         SEL_RAM:        cpu.data2CPU = data4RAM;
         SEL_VRAM:       cpu.data2CPU = 32'(data4VRAM);
         SEL_ROM:        cpu.data2CPU = data4ROM;
         SEL_SWITCH:     cpu.data2CPU = {16'h0000, switch};
         SEL_SEG7:       cpu.data2CPU = seg7_q;
         SEL_VGAMODE:    cpu.data2CPU = {31'h0, vga_mode_q};
         SEL_FORECOLOR:  cpu.data2CPU = {20'h0, fore_q};
         SEL_BACKCOLOR:  cpu.data2CPU = {20'h0, back_q};
         SEL_KBD_DATA:   cpu.data2CPU = {24'h0, kbd_head};
         SEL_KBD_STATUS: cpu.data2CPU = kbd_status(!kbd_empty, kbd_full, 8'(kbd_count));
         SEL_TIMER:      cpu.data2CPU = 32'(timer_q);
         default:        cpu.data2CPU = '0;
      endcase
   end

endmodule

// File: tb/tb_mmio_bus.sv
// Directed bench for mmio_bus: device registers, address decode, keyboard FIFO
// handshake and ordering, full back-pressure, timer load and wrap.
module tb_mmio_bus;
   import mmio_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] addr2RAM;
   logic [31:0] data4RAM, data2RAM, addr2ROM, data4ROM, seg7led;
   logic        we2RAM, we2VRAM, VGAmode, KBDready, KBDread;
   logic [18:0] addr2VRAM;
   logic [11:0] data4VRAM, data2VRAM, forecolor, backcolor;
   logic [15:0] switch;
   logic [7:0]  scancode;
   int          checks = 0;
   int          errors = 0;
   int          ack_count = 0;

   always #5 clk = ~clk;

   mmio_bus_if bus();

   mmio_bus u_dut (
      .clk(clk), .rst(rst), .cpu(bus),
      .addr2RAM(addr2RAM), .data4RAM(data4RAM), .we2RAM(we2RAM), .data2RAM(data2RAM),
      .addr2VRAM(addr2VRAM), .data4VRAM(data4VRAM), .we2VRAM(we2VRAM), .data2VRAM(data2VRAM),
      .addr2ROM(addr2ROM), .data4ROM(data4ROM), .switch(switch), .seg7led(seg7led),
      .VGAmode(VGAmode), .forecolor(forecolor), .backcolor(backcolor),
      .KBDready(KBDready), .scancode(scancode), .KBDread(KBDread)
   );

   always @(posedge KBDread) ack_count++;

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.addr4CPU = a; bus.we4CPU = 1'b0; bus.re4CPU = 1'b0;
      #1 d = bus.data2CPU;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.addr4CPU = a; bus.data4CPU = d; bus.we4CPU = 1'b1; bus.re4CPU = 1'b0;
      @(posedge clk);
      #1 bus.we4CPU = 1'b0;
   endtask

   task automatic pop(output logic [31:0] d);
      @(negedge clk);
      bus.addr4CPU = ADDR_KBD_DATA; bus.we4CPU = 1'b0; bus.re4CPU = 1'b1;
      #1 d = bus.data2CPU;
      @(posedge clk);
      #1 bus.re4CPU = 1'b0;
   endtask

   task automatic kbd_push(input logic [7:0] code, output bit acked, output bit dropped);
      @(negedge clk);
      KBDready = 1'b1; scancode = code; acked = 1'b0;
      for (int i = 0; i < 20 && !acked; i++) begin
         @(negedge clk);
         acked = KBDread;
      end
      KBDready = 1'b0;
      for (int i = 0; i < 20 && KBDread; i++) @(negedge clk);
      dropped = !KBDread;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      rd(ADDR_SWITCH, d);     checks++; if (d !== 32'h0)   begin errors++; $display("FAIL reset_switch got %h want 0", d); end
      rd(ADDR_SEG7, d);       checks++; if (d !== 32'h0)   begin errors++; $display("FAIL reset_seg7 got %h want 0", d); end
      rd(ADDR_VGAMODE, d);    checks++; if (d !== 32'h0)   begin errors++; $display("FAIL reset_vgamode got %h want 0", d); end
      rd(ADDR_FORECOLOR, d);  checks++; if (d !== 32'h0)   begin errors++; $display("FAIL reset_fore got %h want 0", d); end
      rd(ADDR_BACKCOLOR, d);  checks++; if (d !== 32'hfff) begin errors++; $display("FAIL reset_back got %h want fff", d); end
      rd(ADDR_KBD_DATA, d);   checks++; if (d !== 32'h0)   begin errors++; $display("FAIL reset_kbd_data got %h want 0", d); end
      rd(ADDR_KBD_STATUS, d); checks++; if (d !== 32'h0)   begin errors++; $display("FAIL reset_status got %h want 0", d); end
      rd(ADDR_TIMER, d);      checks++; if (d !== 32'h0)   begin errors++; $display("FAIL reset_timer got %h want 0", d); end
      checks++; if (KBDread !== 1'b0) begin errors++; $display("FAIL reset_kbdread got %b want 0", KBDread); end
      checks++; if (backcolor !== 12'hfff || forecolor !== 12'h0 || VGAmode !== 1'b0 || seg7led !== 32'h0) begin
         errors++; $display("FAIL reset_ports back=%h fore=%h vga=%b seg7=%h", backcolor, forecolor, VGAmode, seg7led);
      end
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_fifo_order();
      logic [7:0]  codes [3] = '{8'h1c, 8'h32, 8'h21};
      logic [31:0] d;
      bit          a, dr;
      int          acks0 = ack_count;
      for (int i = 0; i < 3; i++) begin
         kbd_push(codes[i], a, dr);
         checks++; if (!a || !dr) begin errors++; $display("FAIL order_handshake%0d ack=%0b drop=%0b want 1 1", i, a, dr); end
      end
      checks++; if (ack_count - acks0 !== 3) begin errors++; $display("FAIL order_ack_pulses got %0d want 3", ack_count - acks0); end
      rd(ADDR_KBD_STATUS, d); checks++; if (d !== 32'h0301) begin errors++; $display("FAIL order_status got %h want 00000301", d); end
      for (int i = 0; i < 3; i++) begin
         pop(d);
         checks++; if (d !== {24'h0, codes[i]}) begin errors++; $display("FAIL order_pop%0d got %h want %h", i, d, codes[i]); end
      end
      rd(ADDR_KBD_STATUS, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL order_status_empty got %h want 0", d); end
      pop(d);                 checks++; if (d !== 32'h0) begin errors++; $display("FAIL order_pop_empty got %h want 0", d); end
      rd(ADDR_KBD_STATUS, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL order_status_after_empty_pop got %h want 0", d); end
   endtask

   task automatic test_full();
      logic [31:0] d;
      bit          a, dr;
      for (int i = 0; i < 8; i++) kbd_push(8'(8'h10 + i), a, dr);
      @(negedge clk);
      KBDready = 1'b1; scancode = 8'h55;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (KBDread !== 1'b0) begin errors++; $display("FAIL full_backpressure%0d kbdread=%b want 0", i, KBDread); end
      end
      rd(ADDR_KBD_STATUS, d); checks++; if (d !== 32'h0803) begin errors++; $display("FAIL full_status got %h want 00000803", d); end
      pop(d); checks++; if (d !== 32'h10) begin errors++; $display("FAIL full_pop got %h want 10", d); end
      rd(ADDR_KBD_STATUS, d); checks++; if (d !== 32'h0701 || KBDread !== 1'b0) begin
         errors++; $display("FAIL full_pop_blocks_push status=%h kbdread=%b want 00000701 0", d, KBDread);
      end
      rd(ADDR_KBD_STATUS, d); checks++; if (d !== 32'h0803 || KBDread !== 1'b1) begin
         errors++; $display("FAIL full_refill status=%h kbdread=%b want 00000803 1", d, KBDread);
      end
      KBDready = 1'b0;
      @(negedge clk); checks++; if (KBDread !== 1'b0) begin errors++; $display("FAIL full_ack_drop kbdread=%b want 0", KBDread); end
      for (int i = 1; i < 9; i++) begin
         pop(d);
         checks++; if (d !== ((i < 8) ? 32'(8'h10 + i) : 32'h55)) begin errors++; $display("FAIL full_drain%0d got %h", i, d); end
      end
   endtask

   task automatic test_push_pop();
      logic [31:0] d;
      bit          a, dr;
      for (int i = 0; i < 4; i++) kbd_push(8'(8'h41 + i), a, dr);
      @(negedge clk);
      KBDready = 1'b1; scancode = 8'h45;
      bus.addr4CPU = ADDR_KBD_DATA; bus.re4CPU = 1'b1;
      #1 d = bus.data2CPU;
      checks++; if (d !== 32'h41) begin errors++; $display("FAIL pp_head got %h want 41", d); end
      @(posedge clk);
      #1 bus.re4CPU = 1'b0;
      rd(ADDR_KBD_STATUS, d); checks++; if (d !== 32'h0401 || KBDread !== 1'b1) begin
         errors++; $display("FAIL pp_count status=%h kbdread=%b want 00000401 1", d, KBDread);
      end
      KBDready = 1'b0;
      for (int i = 1; i < 5; i++) begin
         pop(d);
         checks++; if (d !== 32'(8'h41 + i)) begin errors++; $display("FAIL pp_drain%0d got %h want %h", i, d, 8'h41 + i); end
      end
   endtask

   task automatic test_reset_mid_handshake();
      logic [31:0] d;
      @(negedge clk); KBDready = 1'b1; scancode = 8'h77;
      @(negedge clk); checks++; if (KBDread !== 1'b1) begin errors++; $display("FAIL mid_ack got %b want 1", KBDread); end
      rst = 1'b1;
      @(posedge clk); #1 checks++; if (KBDread !== 1'b0) begin errors++; $display("FAIL mid_reset_drop got %b want 0", KBDread); end
      rd(ADDR_KBD_STATUS, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_status got %h want 0", d); end
      KBDready = 1'b0; rst = 1'b0;
      rd(ADDR_KBD_STATUS, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_post_status got %h want 0", d); end
   endtask

   task automatic test_timer();
      logic [31:0] d;
      wr(ADDR_TIMER, 32'hffff_fffe);
      rd(ADDR_TIMER, d); checks++; if (d !== 32'hffff_fffe) begin errors++; $display("FAIL timer_load got %h want fffffffe", d); end
      rd(ADDR_TIMER, d); checks++; if (d !== 32'hffff_ffff) begin errors++; $display("FAIL timer_inc got %h want ffffffff", d); end
      rd(ADDR_TIMER, d); checks++; if (d !== 32'h0)         begin errors++; $display("FAIL timer_wrap got %h want 0", d); end
      wr(ADDR_TIMER, 32'h0000_0100);
      rd(ADDR_TIMER, d); checks++; if (d !== 32'h100) begin errors++; $display("FAIL timer_reload got %h want 100", d); end
      rd(ADDR_TIMER, d); checks++; if (d !== 32'h101) begin errors++; $display("FAIL timer_reload_inc got %h want 101", d); end
   endtask

   task automatic test_regs_decode();
      logic [31:0] d;
      wr(ADDR_SEG7, 32'h1234_5678);
      rd(ADDR_SEG7, d); checks++; if (d !== 32'h1234_5678 || seg7led !== 32'h1234_5678) begin
         errors++; $display("FAIL seg7 read=%h port=%h want 12345678", d, seg7led);
      end
      wr(ADDR_VGAMODE, 32'h3);
      rd(ADDR_VGAMODE, d); checks++; if (d !== 32'h1 || VGAmode !== 1'b1) begin errors++; $display("FAIL vgamode read=%h port=%b want 1", d, VGAmode); end
      wr(ADDR_FORECOLOR, 32'hfabc);
      wr(ADDR_BACKCOLOR, 32'h0123);
      rd(ADDR_FORECOLOR, d); checks++; if (d !== 32'habc || forecolor !== 12'habc || backcolor !== 12'h123) begin
         errors++; $display("FAIL colours read=%h fore=%h back=%h want abc abc 123", d, forecolor, backcolor);
      end
      @(negedge clk);
      bus.addr4CPU = 32'h0000_0010; bus.data4CPU = 32'hdead_beef; bus.we4CPU = 1'b1;
      #1 checks++; if (we2RAM !== 1'b1 || we2VRAM !== 1'b0 || addr2RAM !== 12'h4 || data2RAM !== 32'hdead_beef) begin
         errors++; $display("FAIL ram_write we=%b wev=%b addr=%h data=%h want 1 0 4 deadbeef", we2RAM, we2VRAM, addr2RAM, data2RAM);
      end
      bus.addr4CPU = 32'h1000_0020;
      #1 checks++; if (we2VRAM !== 1'b1 || we2RAM !== 1'b0 || addr2VRAM !== 19'h8 || data2VRAM !== 12'heef) begin
         errors++; $display("FAIL vram_write wev=%b we=%b addr=%h data=%h want 1 0 8 eef", we2VRAM, we2RAM, addr2VRAM, data2VRAM);
      end
      bus.addr4CPU = 32'h2000_0040;
      #1 checks++; if (we2VRAM !== 1'b0 || we2RAM !== 1'b0 || addr2ROM !== 32'h2000_0040) begin
         errors++; $display("FAIL rom_write wev=%b we=%b addr=%h want 0 0 20000040", we2VRAM, we2RAM, addr2ROM);
      end
      @(posedge clk); #1 bus.we4CPU = 1'b0;
      switch = 16'hbeef;
      wr(ADDR_SWITCH, 32'h0);
      rd(ADDR_SWITCH, d); checks++; if (d !== 32'hbeef) begin errors++; $display("FAIL switch_ro got %h want 0000beef", d); end
      wr(32'hf000_0020, 32'hffff_ffff);
      rd(ADDR_SEG7, d);       checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL unmapped_write seg7=%h want 12345678", d); end
      rd(32'hf000_0020, d);   checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h want 0", d); end
      rd(32'h3000_0000, d);   checks++; if (d !== 32'h0) begin errors++; $display("FAIL region3_read got %h want 0", d); end
      data4RAM = 32'hcafe_f00d; data4VRAM = 12'habc; data4ROM = 32'h1357_9bdf;
      rd(32'h0000_0100, d); checks++; if (d !== 32'hcafe_f00d) begin errors++; $display("FAIL ram_read got %h want cafef00d", d); end
      rd(32'h1000_0000, d); checks++; if (d !== 32'h0000_0abc) begin errors++; $display("FAIL vram_read got %h want 00000abc", d); end
      rd(32'h2000_0000, d); checks++; if (d !== 32'h1357_9bdf) begin errors++; $display("FAIL rom_read got %h want 13579bdf", d); end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; KBDready = 1'b0; scancode = 8'h00; switch = 16'h0;
      data4RAM = '0; data4VRAM = '0; data4ROM = '0;
      bus.addr4CPU = '0; bus.data4CPU = '0; bus.we4CPU = 1'b0; bus.re4CPU = 1'b0;
      test_reset();
      test_fifo_order();
      test_full();
      test_push_pop();
      test_reset_mid_handshake();
      test_timer();
      test_regs_decode();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
